cam_sccb_config: RTL and testbench

CAM_SCCB_CONFIG -- requirements
Module: cam_sccb_config

---
 rtl/cam_sccb_config.sv | 178 +++++++++++++++++
 tb/tb_cam_sccb_config.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_sccb_config.sv
// SCCB (OV7670) register loader: walks an external table of {addr,data} entries,
// writing each as a 3-phase SCCB transfer, with delay entries (0xFE) and an end marker (0xFF).
module cam_sccb_config #(
   parameter int         CLK_DIV    = 250,
   parameter logic [7:0] DEVICE_ID  = 8'h42,
   parameter int         DELAY_UNIT = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  tbl_index,
   input  logic [15:0] tbl_entry,
   output logic        sioc,
   output logic        siod_oe,
   input  logic        siod_in,
   output logic        busy,
   output logic        done,
   output logic        nack_err
);

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DW = $clog2(255 * DELAY_UNIT + 1);
   localparam logic [QW-1:0] CNT_LAST = QW'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, FETCH, START, BITS, STOP, GAP, DELAY, DONE} state_t;

   state_t          state_reg;
   logic [QW-1:0]   cnt_reg;
   logic [1:0]      qtr_reg;
   logic [4:0]      bit_reg;
   logic [DW-1:0]   dly_cnt_reg;
   logic [DW-1:0]   dly_last_reg;
   logic [26:0]     shift_reg;
   logic            q_end;
   logic            ack_slot;

   assign q_end    = (cnt_reg == CNT_LAST);
   assign ack_slot = (bit_reg == 5'd8) || (bit_reg == 5'd17) || (bit_reg == 5'd26);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         sioc         <= 1'b1;
         siod_oe      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         nack_err     <= 1'b0;
         tbl_index    <= 8'd0;
         cnt_reg      <= '0;
         qtr_reg      <= 2'd0;
         bit_reg      <= 5'd0;
         dly_cnt_reg  <= '0;
         dly_last_reg <= '0;
         shift_reg    <= '0;
      end else begin
         // Quarter timer runs only in bus-timed states and restarts on every quarter
         if ((state_reg inside {START, BITS, STOP, GAP}) && !q_end)
            cnt_reg <= cnt_reg + QW'(1);
         else
            cnt_reg <= '0;

         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_reg <= FETCH;
                  tbl_index <= 8'd0;
                  done      <= 1'b0;
                  nack_err  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            FETCH: begin
               qtr_reg     <= 2'd0;
               bit_reg     <= 5'd0;
               dly_cnt_reg <= '0;
               if (tbl_entry[15:8] == 8'hFF) begin
                  state_reg <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else if (tbl_entry[15:8] == 8'hFE) begin
                  // A zero-length delay costs nothing: move straight to the next entry
                  if (tbl_entry[7:0] == 8'd0) begin
                     tbl_index <= tbl_index + 8'd1;
                  end else begin
                     state_reg    <= DELAY;
                     dly_last_reg <= DW'(tbl_entry[7:0]) * DW'(DELAY_UNIT) - DW'(1);
                  end
               end else begin
                  state_reg <= START;
                  shift_reg <= {DEVICE_ID, 1'b1, tbl_entry[15:8], 1'b1, tbl_entry[7:0], 1'b1};
                  sioc      <= 1'b1;
                  siod_oe   <= 1'b1;
               end
            end
            DELAY: begin
               if (dly_cnt_reg == dly_last_reg) begin
                  state_reg   <= FETCH;
                  dly_cnt_reg <= '0;
                  tbl_index   <= tbl_index + 8'd1;
               end else begin
                  dly_cnt_reg <= dly_cnt_reg + DW'(1);
               end
            end
            START: begin
               if (q_end) begin
                  sioc <= 1'b0;
                  if (qtr_reg == 2'd0) begin
                     qtr_reg <= 2'd1;
                  end else begin
                     state_reg <= BITS;
                     qtr_reg   <= 2'd0;
                     siod_oe   <= ~shift_reg[26];
                  end
               end
            end
            BITS: begin
               if (q_end) begin
                  case (qtr_reg)
                     2'd0: qtr_reg <= 2'd1;
                     2'd1: begin
                        qtr_reg <= 2'd2;
                        sioc    <= 1'b1;
                     end
                     2'd2: begin
                        qtr_reg <= 2'd3;
                        if (ack_slot && siod_in)
                           nack_err <= 1'b1;
                     end
                     default: begin
                        qtr_reg <= 2'd0;
                        sioc    <= 1'b0;
                        if (bit_reg == 5'd26) begin
                           state_reg <= STOP;
                           siod_oe   <= 1'b1;
                        end else begin
                           bit_reg   <= bit_reg + 5'd1;
                           shift_reg <= {shift_reg[25:0], 1'b0};
                           siod_oe   <= ~shift_reg[25];
                        end
                     end
                  endcase
               end
            end
            STOP: begin
               if (q_end) begin
                  case (qtr_reg)
                     2'd0: begin
                        qtr_reg <= 2'd1;
                        sioc    <= 1'b1;
                     end
                     2'd1: begin
                        qtr_reg <= 2'd2;
                        siod_oe <= 1'b0;
                     end
                     default: begin
                        qtr_reg   <= 2'd0;
                        state_reg <= GAP;
                     end
                  endcase
               end
            end
            GAP: begin
               if (q_end) begin
                  if (qtr_reg == 2'd3) begin
                     qtr_reg   <= 2'd0;
                     state_reg <= FETCH;
                     tbl_index <= tbl_index + 8'd1;
                  end else begin
                     qtr_reg <= qtr_reg + 2'd1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_sccb_config.sv
// Bench for cam_sccb_config: an expected-waveform queue built from the table contents,
// a per-cycle compare, a bus protocol monitor and a few literal checks.
module tb_cam_sccb_config;

   localparam int CD = 2;
   localparam int DU = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        siod_in = 1'b0;
   logic [7:0]  tbl_index;
   logic [15:0] tbl_entry;
   logic        sioc, siod_oe, busy, done, nack_err;
   logic [15:0] tbl [256];

   assign tbl_entry = tbl[tbl_index];

   cam_sccb_config #(.CLK_DIV(CD), .DEVICE_ID(8'h42), .DELAY_UNIT(DU)) dut (
      .clk(clk), .rst(rst), .start(start), .tbl_index(tbl_index), .tbl_entry(tbl_entry),
      .sioc(sioc), .siod_oe(siod_oe), .siod_in(siod_in),
      .busy(busy), .done(done), .nack_err(nack_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       sioc;
      logic       oe;
      logic       busy;
      logic       done;
      logic       nack;
      logic [7:0] idx;
   } obs_t;

   obs_t exp_q[$];
   obs_t got_o, want_o;
   int   total = 0;
   int   bad = 0;
   int   n_writes;

   // Monitor state
   int          cyc, first_act, last_act, start_cnt, stop_cnt, cap_n;
   logic [26:0] cap;
   logic        prev_sioc = 1'b1, prev_oe = 1'b0;

   task automatic push_n(input int n, input logic sc, input logic oe, input logic bz,
                         input logic dn, input logic nk, input logic [7:0] ix);
      obs_t o;
      o = {sc, oe, bz, dn, nk, ix};
      for (int i = 0; i < n; i++) exp_q.push_back(o);
   endtask

   // Expected per-cycle bus/status trace for one run, starting with the first FETCH cycle
   task automatic build_model(input logic lvl, input bit wrap_mode);
      logic [7:0]  idx;
      logic [15:0] e;
      logic [26:0] bits;
      logic        nk;
      int          visits;
      idx = 8'd0; nk = 1'b0; visits = 0; n_writes = 0;
      while (visits < 600) begin
         e = tbl[idx];
         if (wrap_mode && visits >= 256 && idx == 8'd1) e = 16'hFF00;
         push_n(1, 1, 0, 1, 0, nk, idx);
         if (e[15:8] == 8'hFF) begin
            push_n(4, 1, 0, 0, 1, nk, idx);
            break;
         end
         if (e[15:8] == 8'hFE) begin
            push_n(int'(e[7:0]) * DU, 1, 0, 1, 0, nk, idx);
         end else begin
            n_writes++;
            bits = {8'h42, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
            push_n(CD, 1, 1, 1, 0, nk, idx);
            push_n(CD, 0, 1, 1, 0, nk, idx);
            for (int b = 26; b >= 0; b--) begin
               push_n(2 * CD, 0, ~bits[b], 1, 0, nk, idx);
               push_n(CD, 1, ~bits[b], 1, 0, nk, idx);
               if (b == 18 || b == 9 || b == 0) nk = nk | lvl;
               push_n(CD, 1, ~bits[b], 1, 0, nk, idx);
            end
            push_n(CD, 0, 1, 1, 0, nk, idx);
            push_n(CD, 1, 1, 1, 0, nk, idx);
            push_n(CD, 1, 0, 1, 0, nk, idx);
            push_n(4 * CD, 1, 0, 1, 0, nk, idx);
         end
         idx = idx + 8'd1;
         visits++;
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         want_o = exp_q.pop_front();
         got_o  = {sioc, siod_oe, busy, done, nack_err, tbl_index};
         total++;
         if (got_o !== want_o) begin
            bad++;
            $display("FAIL trace t=%0t: got sioc=%b oe=%b busy=%b done=%b nack=%b idx=%0d, expected sioc=%b oe=%b busy=%b done=%b nack=%b idx=%0d",
                     $time, got_o.sioc, got_o.oe, got_o.busy, got_o.done, got_o.nack, got_o.idx,
                     want_o.sioc, want_o.oe, want_o.busy, want_o.done, want_o.nack, want_o.idx);
         end
      end
   end

   // SIOD may move only while SIOC is low; a move with SIOC high throughout is a START or STOP condition
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (siod_oe !== prev_oe) begin
            total++;
            if (sioc && !prev_sioc) begin
               bad++;
               $display("FAIL protocol t=%0t: siod_oe changed to %b on sioc rising edge, required no change", $time, siod_oe);
            end else if (sioc && prev_sioc) begin
               if (siod_oe) start_cnt++;
               else stop_cnt++;
            end
         end
         if (sioc && !prev_sioc && cap_n < 27) begin
            cap = {cap[25:0], ~siod_oe};
            cap_n++;
         end
         if (sioc !== 1'b1 || siod_oe !== 1'b0) begin
            if (first_act < 0) first_act = cyc;
            last_act = cyc;
         end
         cyc++;
      end
      prev_sioc = sioc;
      prev_oe   = siod_oe;
   end

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic begin_run(input logic lvl, input bit wrap_mode);
      @(negedge clk);
      siod_in = lvl;
      cyc = 0; first_act = -1; last_act = -1;
      start_cnt = 0; stop_cnt = 0; cap = '0; cap_n = 0;
      start = 1'b1;
      @(posedge clk);
      build_model(lvl, wrap_mode);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20000) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
         total++; bad++;
         $display("FAIL %s timeout: %0d expected cycles left, required 0", name, exp_q.size());
         exp_q.delete();
      end
      $display("run %s: done=%b nack=%b idx=%0d writes=%0d", name, done, nack_err, tbl_index, n_writes);
   endtask

   initial begin
      logic [26:0] pat;
      int n;
      pat = {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1};
      for (int i = 0; i < 256; i++) tbl[i] = 16'hFF00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_sioc", sioc, 1);
      check("reset_oe", siod_oe, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_idx", tbl_index, 0);
      @(negedge clk) rst = 1'b0;

      // Single write 0x12=0x80
      tbl[0] = 16'h1280; tbl[1] = 16'hFF00;
      begin_run(1'b0, 1'b0);
      wait_drain("single");
      check("single_done", done, 1);
      check("single_nack", nack_err, 0);
      check("single_idx", tbl_index, 1);
      check("single_len", (last_act - first_act + 1) + CD, 226);
      check("single_bits", int'(cap), int'(pat));
      check("single_starts", start_cnt, 1);
      check("single_stops", stop_cnt, 1);

      // Delay entry then write
      tbl[0] = 16'hFE03; tbl[1] = 16'h1100; tbl[2] = 16'hFF00;
      begin_run(1'b0, 1'b0);
      wait_drain("delay");
      check("delay_first_act", first_act, 14);
      check("delay_done", done, 1);
      check("delay_idx", tbl_index, 2);
      check("delay_writes", stop_cnt, 1);

      // Every ack slot NACKed
      tbl[0] = 16'h1280; tbl[1] = 16'h1100; tbl[2] = 16'hFF00;
      begin_run(1'b1, 1'b0);
      wait_drain("nack");
      check("nack_flag", nack_err, 1);
      check("nack_done", done, 1);
      check("nack_writes", stop_cnt, 2);

      // Restart from DONE, with a stray start while busy
      tbl[0] = 16'h1280; tbl[1] = 16'hFF00;
      begin_run(1'b0, 1'b0);
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_drain("restart");
      check("restart_nack", nack_err, 0);
      check("restart_idx", tbl_index, 1);
      check("restart_len", (last_act - first_act + 1) + CD, 226);

      // Reset during the 10th bit
      begin_run(1'b0, 1'b0);
      repeat (80) @(negedge clk);
      check("abort_busy_before", busy, 1);
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_sioc", sioc, 1);
      check("abort_oe", siod_oe, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_idx", tbl_index, 0);
      @(negedge clk) rst = 1'b0;
      begin_run(1'b0, 1'b0);
      wait_drain("rerun");
      check("rerun_done", done, 1);
      check("rerun_bits", int'(cap), int'(pat));

      // Index wrap over 256 zero-length delays; end marker appears on the second visit of entry 1
      for (int i = 0; i < 256; i++) tbl[i] = 16'hFE00;
      begin_run(1'b0, 1'b1);
      n = 0;
      while (tbl_index < 8'd128 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("wrap_reach_128", (tbl_index >= 8'd128) ? 1 : 0, 1);
      tbl[1] = 16'hFF00;
      wait_drain("wrap");
      check("wrap_done", done, 1);
      check("wrap_idx", tbl_index, 1);
      check("wrap_writes", start_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
